// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one external W-bit adder among NREQ requesters.
// Optional macro ADD_SCHED_PRIO0_EN: requester 0 always wins the grant when it is valid.
module add_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  input  logic [NREQ-1:0]         req_sub,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  output logic                    add_cin,
  input  logic [W-1:0]            add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_ovf
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] id_reg;
  logic [W-1:0]  op_a_reg;
  logic [W-1:0]  op_b_reg;
  logic          cin_reg;
  logic          rsp_valid_reg;
  logic [IW-1:0] rsp_id_reg;
  logic [W-1:0]  rsp_sum_reg;
  logic          rsp_cout_reg;
  logic          rsp_ovf_reg;

  logic [W-1:0]  a_arr [NREQ];
  logic [W-1:0]  b_arr [NREQ];

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   scan_idx;
  logic [IW-1:0] ptr_next;
  logic [W-1:0]  op_b_next;
  logic          ovf_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // Scan from the farthest offset back to ptr so the nearest valid requester wins last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_reg} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IW+1)'(NREQ);
      end
      if (req_valid[scan_idx[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IW-1:0];
      end
    end
`ifdef ADD_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
`endif
  end

  always_comb begin
    ptr_next  = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    op_b_next = req_sub[grant_idx] ? ~b_arr[grant_idx] : b_arr[grant_idx];
    ovf_next  = (op_a_reg[W-1] == op_b_reg[W-1]) & (add_sum[W-1] != op_a_reg[W-1]);
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state_reg == IDLE) && grant_found
                             && (grant_idx == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      cin_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
      rsp_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            op_a_reg  <= a_arr[grant_idx];
            op_b_reg  <= op_b_next;
            cin_reg   <= req_sub[grant_idx];
            id_reg    <= grant_idx;
            ptr_reg   <= ptr_next;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_reg   <= add_sum;
          rsp_cout_reg  <= add_cout;
          rsp_ovf_reg   <= ovf_next;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // The adder sees only registered operands, never a combinational path from req_*.
  assign add_a     = op_a_reg;
  assign add_b     = op_b_reg;
  assign add_cin   = cin_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: directed and random operations checked against an arithmetic
// reference model; the shared external adder is modelled behaviourally here.
module tb_add_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [W-1:0]      add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout, rsp_ovf;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  add_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v);
`ifdef ADD_SCHED_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the accept edge.
  task automatic do_op(input string tag, input int stall);
    int g, sa, sb, r;
    logic [W-1:0] a, b, e_sum;
    logic s, e_cout, e_ovf;
    logic [NREQ-1:0] e_ready;
    @(negedge clk);
    g = exp_grant(req_valid);
    e_ready = (g < 0) ? '0 : NREQ'(1) << g;
    check({tag, ":req_ready"}, 32'(req_ready), 32'(e_ready));
    if (g < 0) return;
    a = req_a[g*W +: W];
    b = req_b[g*W +: W];
    s = req_sub[g];
    m_ptr = (g + 1) % NREQ;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? sa - sb : sa + sb;
    e_sum  = s ? a - b : a + b;
    e_cout = s ? (a >= b) : ((int'(a) + int'(b)) > 65535);
    e_ovf  = (r > 32767) || (r < -32768);
    @(negedge clk);
    check({tag, ":exec_ready"}, 32'(req_ready), 32'd0);
    check({tag, ":exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":add_a"}, 32'(add_a), 32'(a));
    check({tag, ":add_cin"}, 32'(add_cin), 32'(s));
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ":rsp_sum"}, 32'(rsp_sum), 32'(e_sum));
      check({tag, ":rsp_cout"}, 32'(rsp_cout), 32'(e_cout));
      check({tag, ":rsp_ovf"}, 32'(rsp_ovf), 32'(e_ovf));
      check({tag, ":rsp_id"}, 32'(rsp_id), 32'(g));
      check({tag, ":resp_ready"}, 32'(req_ready), 32'd0);
      if (i < stall) @(negedge clk);
    end
    $display("txn %s: id=%0d a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d stall=%0d",
             tag, g, a, b, s, rsp_sum, rsp_cout, rsp_ovf, stall);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [W-1:0] corner [6];

  initial begin
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'h0001; corner[5] = 16'h8001;
    rst_n = 1'b0; rsp_ready = 1'b0; req_sub = '0; req_a = '0; req_b = '0;
    req_valid = 4'b1111;

    // Reset held two cycles with every request pending
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset:req_ready", 32'(req_ready), 32'd0);
      check("reset:rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset:add_a", 32'(add_a), 32'd0);
      check("reset:rsp_sum", 32'(rsp_sum), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 3), 16'(i + 1), 1'b0);
    do_op("first_grant", 0);

    // Signed overflow on add
    req_valid = 4'b0100;
    set_req(2, 16'h7FFF, 16'h0001, 1'b0);
    do_op("add_ovf", 0);

    // Subtraction with and without borrow
    req_valid = 4'b0010;
    set_req(1, 16'h0005, 16'h0007, 1'b1);
    do_op("sub_borrow", 0);
    set_req(1, 16'h0007, 16'h0005, 1'b1);
    do_op("sub_noborrow", 0);

    // Round-robin rotation with all requests held
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
      do_op($sformatf("rr%0d", n), 0);
    end

    // Backpressure: result held five cycles, then the same requester again
    req_valid = 4'b1000;
    set_req(3, 16'h8000, 16'h0001, 1'b1);
    do_op("backpressure", 5);
    do_op("after_bp", 0);

    // Reset during EXEC drops the in-flight result
    req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1;
    check("midrst:exec_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst:add_a", 32'(add_a), 32'd0);
    check("midrst:req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    req_valid = 4'b1110;
    do_op("post_rst", 0);

    // Random traffic mixing corner operands
    for (int n = 0; n < 30; n++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) == 0)
          set_req(i, corner[$urandom_range(0, 5)], corner[$urandom_range(0, 5)], 1'($urandom));
        else
          set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
      end
      do_op($sformatf("rand%0d", n), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
